// File: rtl/mixed_inputs_pkg.sv
// Shared operator encodings, FSM state type and per-operator identity value
// for the mixed_inputs accumulator family.
package mixed_inputs_pkg;

  localparam int MAX_WIDTH = 1024;

  typedef enum logic [1:0] {
    MODE_OR  = 2'd0,
    MODE_XOR = 2'd1,
    MODE_ADD = 2'd2,
    MODE_AND = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  // Callers size-cast the result down to their own WIDTH.
  function automatic logic [MAX_WIDTH-1:0] identity(input mode_t mode, input int unsigned width);
    identity = (mode == MODE_AND) ? ({MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width)) : '0;
  endfunction

endpackage

// File: rtl/mixed_inputs_acc_if.sv
// Beat input and result output handshakes of the mixed_inputs accumulator.
// master = producer/consumer side, slave = the accumulator.
interface mixed_inputs_acc_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [1:0]                mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          y;
  logic [CW-1:0]             count;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, y, count
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, y, count
  );
endinterface

// File: rtl/mixed_inputs_combine.sv
// Folds CHANNELS words with the selected operator, starting from channel 0.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module mixed_inputs_combine
  import mixed_inputs_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                mode,
  output logic [WIDTH-1:0]          c
);

  always_comb begin
    c = in_data[0 +: WIDTH];
    for (int k = 1; k < CHANNELS; k++) begin
      case (mode_t'(mode))
        MODE_OR:  c = c | in_data[k*WIDTH +: WIDTH];
        MODE_XOR: c = c ^ in_data[k*WIDTH +: WIDTH];
        MODE_ADD: c = c + in_data[k*WIDTH +: WIDTH];
        default:  c = c & in_data[k*WIDTH +: WIDTH];
      endcase
    end
  end

endmodule

// File: rtl/mixed_inputs_acc.sv
// Accumulates DEPTH beats of combined channel words into one held result.
// Latency: y/out_valid update on the edge accepting the DEPTH-th beat.
// Backpressure: in_ready drops in HOLD until out_ready drains the result.
module mixed_inputs_acc
  import mixed_inputs_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  mixed_inputs_acc_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  acc_state_t       state;
  mode_t            mode_q;
  mode_t            eff_mode;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] beat_c;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] y_q;
  logic [CW-1:0]    count_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept;

  // The first beat of a group runs on the live mode and a fresh identity,
  // so the group's operator is decided before mode_q is loaded.
  assign eff_mode = (state == IDLE) ? mode_t'(bus.mode) : mode_q;
  assign base     = (state == IDLE) ? WIDTH'(identity(eff_mode, WIDTH)) : acc;
  assign accept   = bus.in_valid && in_ready_q;

  mixed_inputs_combine #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_beat (
    .in_data (bus.in_data),
    .mode    (eff_mode),
    .c       (beat_c)
  );

  mixed_inputs_combine #(.WIDTH(WIDTH), .CHANNELS(2)) u_step (
    .in_data ({beat_c, base}),
    .mode    (eff_mode),
    .c       (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= MODE_OR;
      acc         <= '0;
      y_q         <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            if (state == IDLE) mode_q <= eff_mode;
            if (count_q == CW'(DEPTH - 1)) begin
              state       <= HOLD;
              y_q         <= acc_next;
              count_q     <= CW'(DEPTH);
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state   <= ACCUM;
              count_q <= count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            count_q     <= '0;
            acc         <= WIDTH'(identity(mode_q, WIDTH));
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_mixed_inputs_acc.sv
// Scoreboard bench for mixed_inputs_acc: default 32x2x4 instance plus an 8x3x1 instance.
module tb_mixed_inputs_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mixed_inputs_acc_if #(.WIDTH(32), .CHANNELS(2), .DEPTH(4)) a ();
  mixed_inputs_acc_if #(.WIDTH(8),  .CHANNELS(3), .DEPTH(1)) g ();

  mixed_inputs_acc #(.WIDTH(32), .CHANNELS(2), .DEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  mixed_inputs_acc #(.WIDTH(8),  .CHANNELS(3), .DEPTH(1)) dut_g (.clk(clk), .rst(rst), .bus(g.slave));

  int checks = 0;
  int passes = 0;
  logic [31:0] sb_q[$];
  logic [7:0]  sb_g[$];

  function automatic logic [31:0] tb_op(input logic [1:0] m, input logic [31:0] x, input logic [31:0] z);
    case (m)
      2'd0:    return x | z;
      2'd1:    return x ^ z;
      2'd2:    return x + z;
      default: return x & z;
    endcase
  endfunction

  task automatic send_a(input logic [31:0] da, input logic [31:0] db, input logic [1:0] m);
    a.in_valid = 1'b1;
    a.in_data  = {db, da};
    a.mode     = m;
    @(posedge clk);
    @(negedge clk);
    a.in_valid = 1'b0;
  endtask

  task automatic wait_valid_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_a();
    a.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (a.out_valid !== 1'b0 || a.y !== 32'h0 || a.count !== 3'd0 || a.in_ready !== 1'b1)
      $display("FAIL reset_during: ov=%b y=%h cnt=%0d ir=%b want 0/0/0/1", a.out_valid, a.y, a.count, a.in_ready);
    else passes++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a.out_valid !== 1'b0 || a.y !== 32'h0 || a.count !== 3'd0 || a.in_ready !== 1'b1)
      $display("FAIL reset_idle: ov=%b y=%h cnt=%0d ir=%b want 0/0/0/1", a.out_valid, a.y, a.count, a.in_ready);
    else passes++;
    checks++;
    if (g.out_valid !== 1'b0 || g.y !== 8'h0 || g.count !== 1'b0 || g.in_ready !== 1'b1)
      $display("FAIL reset_generic: ov=%b y=%h cnt=%0d ir=%b want 0/0/0/1", g.out_valid, g.y, g.count, g.in_ready);
    else passes++;
  endtask

  task automatic test_or_group();
    logic [31:0] exp;
    send_a(32'h0000_0001, 32'h0, 2'd0);
    checks++;
    if (a.count !== 3'd1 || a.out_valid !== 1'b0)
      $display("FAIL or_count1: cnt=%0d ov=%b want 1/0", a.count, a.out_valid);
    else passes++;
    send_a(32'h0000_1000, 32'h0, 2'd0);
    send_a(32'h1000_0000, 32'h0, 2'd0);
    send_a(32'h0,         32'h0000_0001, 2'd0);
    sb_q.push_back(32'h1000_1001);
    checks++;
    if (a.out_valid !== 1'b1 || a.count !== 3'd4)
      $display("FAIL or_latency: ov=%b cnt=%0d want 1/4", a.out_valid, a.count);
    else passes++;
    exp = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a.y !== exp || a.out_valid !== 1'b1 || a.in_ready !== 1'b0 || a.count !== 3'd4)
        $display("FAIL or_hold%0d: y=%h ov=%b ir=%b cnt=%0d want %h/1/0/4", i, a.y, a.out_valid, a.in_ready, a.count, exp);
      else passes++;
      @(negedge clk);
    end
    release_a();
    checks++;
    if (a.out_valid !== 1'b0 || a.count !== 3'd0 || a.in_ready !== 1'b1)
      $display("FAIL or_drain: ov=%b cnt=%0d ir=%b want 0/0/1", a.out_valid, a.count, a.in_ready);
    else passes++;
  endtask

  task automatic test_add_wrap();
    bit ok;
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) send_a(32'hFFFF_FFFF, 32'h0000_0001, 2'd2);
    sb_q.push_back(32'h0000_0000);
    wait_valid_a(ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || a.y !== exp) $display("FAIL add_wrap: ok=%b y=%h want %h", ok, a.y, exp);
    else passes++;
    release_a();
    for (int i = 0; i < 4; i++) send_a(32'h0000_0001, 32'h0000_1000, 2'd2);
    sb_q.push_back(32'h0000_4004);
    wait_valid_a(ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || a.y !== exp) $display("FAIL add_second: ok=%b y=%h want %h", ok, a.y, exp);
    else passes++;
    release_a();
  endtask

  task automatic test_mode_change();
    bit ok;
    logic [31:0] exp;
    send_a(32'hFFFF_FFFF, 32'h1000_1000, 2'd3);
    for (int i = 0; i < 3; i++) send_a(32'h1000_0000, 32'hFFFF_FFFF, 2'd0);
    sb_q.push_back(32'h1000_0000);
    wait_valid_a(ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || a.y !== exp) $display("FAIL mode_latch: ok=%b y=%h want %h", ok, a.y, exp);
    else passes++;
    release_a();
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [31:0] exp;
    send_a(32'h0000_0005, 32'h0000_0006, 2'd2);
    send_a(32'h0000_0007, 32'h0000_0008, 2'd2);
    checks++;
    if (a.count !== 3'd2 || a.y !== 32'h1000_0000)
      $display("FAIL arst_pre: cnt=%0d y=%h want 2/10000000", a.count, a.y);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a.count !== 3'd0 || a.y !== 32'h0 || a.out_valid !== 1'b0 || a.in_ready !== 1'b1)
      $display("FAIL arst_clear: cnt=%0d y=%h ov=%b ir=%b want 0/0/0/1", a.count, a.y, a.out_valid, a.in_ready);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a.out_valid !== 1'b0 || a.count !== 3'd0)
      $display("FAIL arst_release: ov=%b cnt=%0d want 0/0", a.out_valid, a.count);
    else passes++;
    for (int i = 0; i < 4; i++) send_a(32'h0000_0001, 32'h0000_1000, 2'd1);
    sb_q.push_back(32'h0000_0000);
    wait_valid_a(ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || a.y !== exp || a.count !== 3'd4)
      $display("FAIL arst_xor: ok=%b y=%h cnt=%0d want %h/4", ok, a.y, a.count, exp);
    else passes++;
    release_a();
  endtask

  task automatic test_random_groups();
    bit ok;
    logic [31:0] exp, acc, da, db;
    logic [1:0]  m;
    for (int grp = 0; grp < 6; grp++) begin
      m   = 2'($urandom_range(0, 3));
      acc = (m == 2'd3) ? 32'hFFFF_FFFF : 32'h0;
      for (int b = 0; b < 4; b++) begin
        da  = $urandom;
        db  = $urandom;
        acc = tb_op(m, acc, tb_op(m, da, db));
        send_a(da, db, (b == 0) ? m : 2'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      sb_q.push_back(acc);
      wait_valid_a(ok);
      exp = sb_q.pop_front();
      checks++;
      if (!ok || a.y !== exp) $display("FAIL rand_grp%0d: mode=%0d ok=%b y=%h want %h", grp, m, ok, a.y, exp);
      else passes++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_a();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d0, d1, d2, exp;
    int results;
    g.in_data  = {8'h01, 8'hF0, 8'h0F};
    g.mode     = 2'd1;
    g.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    g.in_valid = 1'b0;
    checks++;
    if (g.out_valid !== 1'b1 || g.y !== 8'hFE || g.count !== 1'b1 || g.in_ready !== 1'b0)
      $display("FAIL gen_first: ov=%b y=%h cnt=%0d ir=%b want 1/fe/1/0", g.out_valid, g.y, g.count, g.in_ready);
    else passes++;
    g.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    results = 0;
    g.in_valid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (g.out_valid === 1'b1) begin
        results++;
        exp = sb_g.pop_front();
        checks++;
        if (g.y !== exp) $display("FAIL gen_b2b%0d: y=%h want %h", cyc, g.y, exp);
        else passes++;
      end
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
      g.in_data = {d2, d1, d0};
      if (g.in_ready === 1'b1) sb_g.push_back(d0 ^ d1 ^ d2);
      @(posedge clk);
      @(negedge clk);
    end
    g.in_valid  = 1'b0;
    g.out_ready = 1'b0;
    checks++;
    if (results != 4) $display("FAIL gen_rate: results=%0d want 4", results);
    else passes++;
  endtask

  initial begin
    a.in_valid = 1'b0; a.in_data = '0; a.mode = 2'd0; a.out_ready = 1'b0;
    g.in_valid = 1'b0; g.in_data = '0; g.mode = 2'd0; g.out_ready = 1'b0;
    test_reset();
    test_or_group();
    test_add_wrap();
    test_mode_change();
    test_async_reset();
    test_random_groups();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
